data_mem_mmio: RTL and testbench



---
 rtl/data_mem_mmio.sv | 130 +++++++++++++
 tb/tb_data_mem_mmio.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// ============================================================================
// data_mem_mmio: word RAM with byte-enable writes plus an MMIO window
// (timer with interrupt, LED, digit, systick). Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_mmio #(
  parameter int         RAM_ADDR_BITS = 9,
  parameter int         LED_WIDTH     = 8,
  parameter int         DIGI_WIDTH    = 12,
  parameter logic [3:0] MMIO_NIBBLE   = 4'h4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            byte_en,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  addr_err,
  output logic [LED_WIDTH-1:0]  led,
  output logic [DIGI_WIDTH-1:0] digi,
  output logic                  irq
);

  localparam int         c_RAM_DEPTH = 1 << RAM_ADDR_BITS;
  localparam logic [2:0] c_SEL_TH    = 3'd0;
  localparam logic [2:0] c_SEL_TL    = 3'd1;
  localparam logic [2:0] c_SEL_TCON  = 3'd2;
  localparam logic [2:0] c_SEL_LED   = 3'd3;
  localparam logic [2:0] c_SEL_DIGI  = 3'd4;
  localparam logic [2:0] c_SEL_TICK  = 3'd5;

  logic [31:0] r_ram [c_RAM_DEPTH];
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [31:0] r_systick;

  logic [RAM_ADDR_BITS-1:0] w_ram_idx;
  logic [2:0]               w_sel;
  logic                     w_is_ram;
  logic                     w_is_mmio;
  logic                     w_is_err;
  logic                     w_mmio_wr;
  logic                     w_ovf;
  logic                     w_set_status;
  logic [31:0]              w_rd_data;
  logic                     w_unused_addr;

  assign w_ram_idx     = addr[RAM_ADDR_BITS+1:2];
  assign w_sel         = addr[4:2];
  assign w_is_ram      = (addr[31:RAM_ADDR_BITS+2] == '0);
  assign w_is_mmio     = (addr[31:28] == MMIO_NIBBLE) && (addr[27:5] == '0) &&
                         (w_sel <= c_SEL_TICK);
  assign w_is_err      = !w_is_ram && !w_is_mmio;
  assign w_mmio_wr     = mem_write && w_is_mmio;
  assign w_unused_addr = &{1'b0, addr[1:0]};

  assign w_ovf        = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
  assign w_set_status = w_ovf && r_tcon[1];
  assign irq          = r_tcon[2];

  always_comb begin
    w_rd_data = '0;
    if (w_is_ram) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_is_mmio) begin
      case (w_sel)
        c_SEL_TH:   w_rd_data = r_th;
        c_SEL_TL:   w_rd_data = r_tl;
        c_SEL_TCON: w_rd_data = {29'd0, r_tcon};
        c_SEL_LED:  w_rd_data = 32'(led);
        c_SEL_DIGI: w_rd_data = 32'(digi);
        c_SEL_TICK: w_rd_data = r_systick;
        default:    w_rd_data = '0;
      endcase
    end
  end

  // RAM array is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (mem_write && w_is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) r_ram[w_ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      addr_err  <= 1'b0;
      led       <= '0;
      digi      <= '0;
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_systick <= '0;
    end else begin
      rvalid    <= mem_read;
      addr_err  <= (mem_read || mem_write) && w_is_err;
      r_systick <= r_systick + 32'd1;
      if (mem_read) rdata <= w_rd_data;

      if (w_mmio_wr && w_sel == c_SEL_TL) begin
        r_tl <= wdata;
      end else if (r_tcon[0]) begin
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      end

      // Overflow status is OR-ed into a TCON write so no interrupt is lost
      if (w_mmio_wr && w_sel == c_SEL_TCON) begin
        r_tcon <= {wdata[2] | w_set_status, wdata[1:0]};
      end else if (w_set_status) begin
        r_tcon[2] <= 1'b1;
      end

      if (w_mmio_wr && w_sel == c_SEL_TH)   r_th <= wdata;
      if (w_mmio_wr && w_sel == c_SEL_LED)  led  <= wdata[LED_WIDTH-1:0];
      if (w_mmio_wr && w_sel == c_SEL_DIGI) digi <= wdata[DIGI_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
// ============================================================================
// tb_data_mem_mmio: directed plus randomized checks against a behavioural
// model of the RAM, MMIO registers and timer. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_mmio;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        rvalid;
  logic        addr_err;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  data_mem_mmio #(
    .RAM_ADDR_BITS(9),
    .LED_WIDTH    (8),
    .DIGI_WIDTH   (12),
    .MMIO_NIBBLE  (4'h4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .byte_en  (byte_en),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .addr_err (addr_err),
    .led      (led),
    .digi     (digi),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_ram [512];
  bit          m_known [512];
  logic [31:0] m_th, m_tl, m_tick, m_rdata;
  bit          m_en, m_ie, m_st, m_rknown, m_rvalid, m_err;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_0800) return 0;
    if (a[31:28] == 4'h4 && a[27:5] == 23'd0 && a[4:2] < 3'd6) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_tick = 0; m_rdata = 0;
    m_en = 0; m_ie = 0; m_st = 0; m_rknown = 1; m_rvalid = 0; m_err = 0;
    m_led = 0; m_digi = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(m_rvalid));
    chk({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
    chk({tag, ".led"}, 32'(led), 32'(m_led));
    chk({tag, ".digi"}, 32'(digi), 32'(m_digi));
    chk({tag, ".irq"}, 32'(irq), 32'(m_st));
    if (m_rknown) chk({tag, ".rdata"}, rdata, m_rdata);
  endtask

  // One bus cycle: drive, predict, clock, check
  task automatic cyc(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    int          rg;
    logic [31:0] rv, ntl;
    bit          rv_known, ovf, setst;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; byte_en = be;
    rg = region(a);
    rv = 0; rv_known = 1;
    if (rg == 0) begin
      rv = m_ram[a[10:2]]; rv_known = m_known[a[10:2]];
    end else if (rg == 1) begin
      case (a[4:2])
        3'd0: rv = m_th;
        3'd1: rv = m_tl;
        3'd2: rv = {29'd0, m_st, m_ie, m_en};
        3'd3: rv = {24'd0, m_led};
        3'd4: rv = {20'd0, m_digi};
        default: rv = m_tick;
      endcase
    end
    ovf   = m_en && (m_tl == 32'hFFFF_FFFF);
    setst = ovf && m_ie;
    ntl   = !m_en ? m_tl : (ovf ? m_th : m_tl + 1);
    m_st  = m_st | setst;
    if (wr && rg == 0) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) m_ram[a[10:2]][8*i +: 8] = wd[8*i +: 8];
      if (be == 4'hF) m_known[a[10:2]] = 1;
    end
    if (wr && rg == 1) begin
      case (a[4:2])
        3'd0: m_th = wd;
        3'd1: ntl = wd;
        3'd2: begin m_en = wd[0]; m_ie = wd[1]; m_st = wd[2] | setst; end
        3'd3: m_led = wd[7:0];
        3'd4: m_digi = wd[11:0];
        default: ;
      endcase
    end
    m_tl = ntl;
    m_tick = m_tick + 1;
    if (rd) begin m_rdata = rv; m_rknown = rv_known; end
    m_rvalid = rd;
    m_err    = (rd || wr) && (rg == 2);
    @(posedge clk); #1;
    check_outputs("cyc");
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    int          k;
    logic [31:0] a, wd;
    reset = 1; addr = 0; wdata = 0; mem_read = 0; mem_write = 0; byte_en = 0;
    for (int i = 0; i < 512; i++) begin m_ram[i] = 0; m_known[i] = 0; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.addr_err", 32'(addr_err), 32'd0);
    chk("rst.led", 32'(led), 32'd0);
    chk("rst.digi", 32'(digi), 32'd0);
    chk("rst.irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 32; i++) cyc(0, 1, 32'(i * 4), $urandom, 4'hF);

    // Byte-lane merge
    cyc(0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    cyc(0, 1, 32'h40, 32'h0000_00AA, 4'b0001);
    cyc(1, 0, 32'h40, 0, 0);
    chk("be_merge", rdata, 32'hDEAD_BEAA);
    chk("be_merge.rvalid", 32'(rvalid), 32'd1);

    // Read-first on simultaneous read/write
    cyc(0, 1, 32'h80, 32'h1111_1111, 4'hF);
    cyc(1, 1, 32'h80, 32'h2222_2222, 4'hF);
    chk("rfirst.old", rdata, 32'h1111_1111);
    cyc(1, 0, 32'h80, 0, 0);
    chk("rfirst.new", rdata, 32'h2222_2222);

    // Error accesses
    cyc(0, 1, 32'h0, 32'h1234_5678, 4'hF);
    cyc(1, 1, 32'h0000_0800, 32'hFFFF_FFFF, 4'hF);
    chk("err_ram.flag", 32'(addr_err), 32'd1);
    chk("err_ram.rdata", rdata, 32'd0);
    cyc(1, 1, 32'h4000_0020, 32'hFFFF_FFFF, 4'hF);
    chk("err_mmio.flag", 32'(addr_err), 32'd1);
    cyc(1, 0, 32'h0, 0, 0);
    chk("err.word0", rdata, 32'h1234_5678);
    cyc(0, 1, 32'h4000_0014, 32'h5, 4'hF);
    chk("tick_wr.no_err", 32'(addr_err), 32'd0);

    // Timer overflow, reload, irq, clear, and overflow-coincident TCON write
    cyc(0, 1, 32'h4000_0000, 32'hFFFF_FFFD, 4'hF);
    cyc(0, 1, 32'h4000_0004, 32'hFFFF_FFFE, 4'hF);
    cyc(0, 1, 32'h4000_0008, 32'h3, 4'hF);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("tmr.irq_set", 32'(irq), 32'd1);
    cyc(1, 0, 32'h4000_0004, 0, 0);
    chk("tmr.reload", rdata, 32'hFFFF_FFFD);
    cyc(0, 1, 32'h4000_0008, 32'h3, 4'hF);
    chk("tmr.irq_clr", 32'(irq), 32'd0);
    cyc(0, 1, 32'h4000_0008, 32'h3, 4'hF);
    chk("tmr.ovf_wr", 32'(irq), 32'd1);
    cyc(0, 1, 32'h4000_0008, 32'h0, 4'hF);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      k  = $urandom_range(0, 99);
      wd = $urandom;
      if (k < 50) begin
        a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      end else if (k < 88) begin
        a = {4'h4, 23'd0, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
        if (a[4:2] == 3'd1 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (a[4:2] == 3'd0 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      end else if (k < 94) begin
        a = {4'h4, 28'($urandom_range(0, 255))};
      end else begin
        a = $urandom;
      end
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd, 4'($urandom));
    end

    // Asynchronous reset mid-count
    cyc(0, 1, 32'h4000_000C, 32'h5A, 4'hF);
    cyc(0, 1, 32'h4000_0010, 32'hABC, 4'hF);
    cyc(0, 1, 32'h4000_0008, 32'h3, 4'hF);
    cyc(1, 0, 32'h4000_000C, 0, 0);
    chk("pre_rst.led", 32'(led), 32'h5A);
    chk("pre_rst.digi", 32'(digi), 32'hABC);
    #2 reset = 1;
    #1;
    chk("arst.led", 32'(led), 32'd0);
    chk("arst.digi", 32'(digi), 32'd0);
    chk("arst.irq", 32'(irq), 32'd0);
    chk("arst.rvalid", 32'(rvalid), 32'd0);
    chk("arst.rdata", rdata, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    cyc(1, 0, 32'h4000_0014, 0, 0);
    chk("arst.systick", rdata, 32'd0);
    cyc(1, 0, 32'h4000_0004, 0, 0);
    chk("arst.tl", rdata, 32'd0);
    cyc(1, 0, 32'h40, 0, 0);
    cyc(1, 0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
